srl_seq: RTL
============

Name: srl_seq

Overview:
- Iterative right-shift unit; the counterpart to the combinational left-shift-by-2 used for branch/jump offsets.
- Executes srl/sra for the ALU's multi-cycle path, shifting one bit per clock under a start/busy/done handshake.
- Sits beside the ALU in the execute stage; the controller stalls on busy and captures result on done.
- Keeps area small versus a full barrel shifter.

Parameters:
- n, 32, data width in bits.
- SHW, $clog2(n) = 5, shift-amount width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- arith  input  1  0 = logical (zero fill), 1 = arithmetic (sign fill).
- num  input  n  operand.
- shamt  input  SHW  shift amount, 0..n-1.
- result  output  n  shifted value; valid while done=1, held until the next accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): state=IDLE, result=0, count=0, fill=0, busy=0, done=0.
- Reset mid-operation aborts immediately. No done pulse follows.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE. All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- Accepting start (IDLE or DONE, start=1):
  - result <= num.
  - count <= shamt.
  - fill <= arith ? num[n-1] : 0.
  - If shamt==0, next state is DONE; otherwise next state is SHIFT.
- SHIFT, each edge:
  - result <= {fill, result[n-1:1]}.
  - count <= count-1.
  - If count==1, next state is DONE; otherwise stay in SHIFT.
- DONE lasts one cycle:
  - start=1 is accepted as above (back-to-back operation).
  - Otherwise go to IDLE, with result held.
- Latency: done is high in the (shamt+1)th cycle after the start cycle.
  - shamt=0 gives 1 cycle. busy never rises.
  - shamt=31 gives 32 cycles. busy is high for 31 cycles.
- start while busy is ignored. Inputs num, shamt and arith are don't-care except on the accepting edge.
- The sign fill bit is captured at start, so the sign is preserved across all iterations.
- No overflow: bits shifted out of the LSB are discarded.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sr_state_t;
  - localparam SHIFT_LOGICAL=1'b0, SHIFT_ARITH=1'b1.
- One natural combinational sub-module, sr1: a single-step right shift with a fill-bit input. It is instantiated once in the SHIFT datapath.
- FSM and counter stay in srl_seq.

Test Plan:
1. Logical shift: num=32'hF0000000, shamt=4, arith=0, start for 1 cycle -> busy high 4 cycles, done in cycle 5, result=32'h0F000000.
2. Arithmetic shift: same operands with arith=1 -> result=32'hFF000000, done in cycle 5.
3. Zero shift amount: num=32'h13579BDF, shamt=0 -> busy stays 0, done in cycle 1, result=32'h13579BDF.
4. Maximum shift amount: num=32'hFFFFFFFF, shamt=31 -> with arith=0, result=32'h00000001 at cycle 32; with arith=1, result=32'hFFFFFFFF at cycle 32.
5. Start ignored while busy: num=32'h0000BEEF, shamt=8, arith=0; at cycle 3 pulse start with num=32'h11111111 -> ignored; done at cycle 9 with result=32'h000000BE.
   - Reset mid-shift: repeat the first operation, assert reset at cycle 3 -> result, busy and done are 0 immediately, and no done pulse occurs.
6. Back-to-back: during the done cycle of test 1, start num=32'h0000BEEF, shamt=2, arith=0 -> no IDLE gap, busy next cycle, done 3 cycles after the DONE cycle, result=32'h00002FBB.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift sequencer state encoding and shift-kind selects.
// Imported by the execute-stage shift sequencer and its datapath.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sr_state_t;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

endpackage

// File: rtl/srl_seq_sr1.sv
// sr1: single-step right shift, vacated MSB taken from fill.
// Ports: din (operand), fill (bit entering MSB), dout (shifted value).
module sr1 #(
  parameter int n = 32
) (
  input  logic [n-1:0] din,
  input  logic         fill,
  output logic [n-1:0] dout
);

  assign dout = {fill, din[n-1:1]};

endmodule

// File: rtl/srl_seq.sv
// srl_seq: iterative srl/sra, one bit per clock, start/busy/done handshake.
// Ports: clk, reset (async high), start, arith, num, shamt -> result, busy, done.
module srl_seq
  import cpu_pkg::*;
#(
  parameter int n   = 32,
  parameter int SHW = $clog2(n)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           arith,
  input  logic [n-1:0]   num,
  input  logic [SHW-1:0] shamt,
  output logic [n-1:0]   result,
  output logic           busy,
  output logic           done
);

  sr_state_t      state;
  logic [SHW-1:0] count;
  logic           fill;
  logic [n-1:0]   step;

  sr1 #(.n(n)) u_sr1 (
    .din  (result),
    .fill (fill),
    .dout (step)
  );

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      fill   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            result <= num;
            count  <= shamt;
            // Sign captured once so every step refills with it.
            fill   <= (arith == SHIFT_ARITH) ? num[n-1] : 1'b0;
            state  <= (shamt == '0) ? DONE : SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          result <= step;
          count  <= count - 1'b1;
          if (count == SHW'(1))
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
